// File: rtl/wave_capture.sv
// Oscilloscope-style capture buffer: scales microphone samples into a 1280-entry
// line buffer, optionally aligned to a rising mid-scale crossing, for VGA readout.

module wave_capture (
  input  logic        CLK_VGA,
  input  logic        rst_n,
  input  logic        sample_en,
  input  logic [11:0] mic_in,
  input  logic        trig_en,
  input  logic        freeze,
  input  logic [11:0] VGA_HORZ_COORD,
  output logic [9:0]  wave_sample,
  output logic        wr_busy,
  output logic        frame_done
);

  localparam int unsigned Depth = 1280;
  localparam int unsigned AddrW = 11;
  localparam int unsigned TmoW  = 11;

  localparam logic [AddrW-1:0] LastAddr  = AddrW'(Depth - 1);
  localparam logic [TmoW-1:0]  TmoMax    = {TmoW{1'b1}};
  localparam logic [11:0]      DepthCoord = 12'(Depth);

  typedef enum logic [1:0] {
    StArm,
    StWaitTrig,
    StFill,
    StHold
  } state_e;

  state_e            state_q, state_d;
  logic [AddrW-1:0]  addr_q, addr_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [9:0]        prev_q, prev_d;
  logic              frame_done_q, frame_done_d;
  logic [9:0]        rd_q, rd_d;

  logic [9:0]        mem [Depth];

  logic [9:0]        scaled;
  logic              crossing;
  logic              trig_hit;
  logic              we;
  logic [AddrW-1:0]  waddr;
  logic              last_wr;
  logic              unused_mic;

  assign scaled     = mic_in[11:2];
  assign unused_mic = ^mic_in[1:0];

  // Mid-scale is 512, so the crossing test reduces to the MSBs.
  assign crossing = ~prev_q[9] & scaled[9];
  assign trig_hit = sample_en & (crossing | (tmo_q == TmoMax));

  // State register and datapath flops
  always_ff @(posedge CLK_VGA) begin
    if (!rst_n) begin
      state_q      <= StArm;
      addr_q       <= '0;
      tmo_q        <= '0;
      prev_q       <= '0;
      frame_done_q <= 1'b0;
      rd_q         <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tmo_q        <= tmo_d;
      prev_q       <= prev_d;
      frame_done_q <= frame_done_d;
      rd_q         <= rd_d;
    end
  end

  // Sample buffer: no reset, contents persist across frames and resets.
  always_ff @(posedge CLK_VGA) begin
    if (we) begin
      mem[waddr] <= scaled;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StArm: begin
        if (!freeze) begin
          addr_d  = '0;
          tmo_d   = '0;
          state_d = trig_en ? StWaitTrig : StFill;
        end
      end
      StWaitTrig: begin
        if (trig_hit) begin
          addr_d  = AddrW'(1);
          state_d = StFill;
        end else if (sample_en) begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StFill: begin
        if (sample_en) begin
          addr_d = addr_q + AddrW'(1);
          if (addr_q == LastAddr) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (!freeze) begin
          state_d = StArm;
        end
      end
      default: state_d = StArm;
    endcase
  end

  // Output / write-port logic
  always_comb begin
    we      = 1'b0;
    waddr   = addr_q;
    last_wr = 1'b0;
    unique case (state_q)
      StWaitTrig: begin
        if (trig_hit) begin
          we    = 1'b1;
          waddr = '0;
        end
      end
      StFill: begin
        if (sample_en) begin
          we      = 1'b1;
          last_wr = (addr_q == LastAddr);
        end
      end
      default: begin
        we = 1'b0;
      end
    endcase
    // Reset wins over a coincident strobe.
    we      = we & rst_n;
    wr_busy = (state_q == StWaitTrig) || (state_q == StFill);
  end

  always_comb begin
    prev_d       = sample_en ? scaled : prev_q;
    frame_done_d = last_wr;
    rd_d         = '0;
    if (VGA_HORZ_COORD < DepthCoord) begin
      rd_d = mem[VGA_HORZ_COORD[AddrW-1:0]];
    end
  end

  assign wave_sample = rd_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: free-run, trigger, auto-trigger, freeze,
// read-port corner cases and mid-frame reset.

module tb_wave_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_en;
  logic [11:0] mic_in;
  logic        trig_en;
  logic        freeze;
  logic [11:0] vga;
  logic [9:0]  wave_sample;
  logic        wr_busy;
  logic        frame_done;

  int vectors     = 0;
  int miscompares = 0;
  int fd_cnt      = 0;

  logic [9:0] rv;

  always #5 clk = ~clk;

  wave_capture dut (
    .CLK_VGA        (clk),
    .rst_n          (rst_n),
    .sample_en      (sample_en),
    .mic_in         (mic_in),
    .trig_en        (trig_en),
    .freeze         (freeze),
    .VGA_HORZ_COORD (vga),
    .wave_sample    (wave_sample),
    .wr_busy        (wr_busy),
    .frame_done     (frame_done)
  );

  always @(posedge clk) begin
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle strobe; returns at the following negedge with sample_en low.
  task automatic strobe(input logic [11:0] v);
    sample_en = 1'b1;
    mic_in    = v;
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [9:0] v);
    vga = a;
    @(negedge clk);
    v = wave_sample;
  endtask

  int fr_addr [6] = '{0, 1, 513, 1023, 1024, 1279};

  initial begin
    rst_n     = 1'b0;
    sample_en = 1'b0;
    mic_in    = '0;
    trig_en   = 1'b0;
    freeze    = 1'b0;
    vga       = '0;
    cyc(3);
    check("rst_wave_sample", wave_sample, 0);
    check("rst_wr_busy", wr_busy, 0);
    check("rst_frame_done", frame_done, 0);

    // Free-run frame
    rst_n = 1'b1;
    cyc(1);
    check("freerun_busy", wr_busy, 1);
    for (int k = 0; k < 1279; k++) strobe(12'(k * 4));
    check("fd_before_last", fd_cnt, 0);
    check("fd_low_before_last", frame_done, 0);
    strobe(12'(1279 * 4));
    check("fd_pulse", frame_done, 1);
    check("hold_busy", wr_busy, 0);
    cyc(3);
    check("fd_single_cycle", frame_done, 0);
    check("fd_once", fd_cnt, 1);
    for (int i = 0; i < 6; i++) begin
      rd(12'(fr_addr[i]), rv);
      check($sformatf("freerun_buf[%0d]", fr_addr[i]), rv, fr_addr[i] % 1024);
    end
    rd(12'd1500, rv);
    check("oob_read", rv, 0);
    check("rearm_fill", wr_busy, 1);

    // Read-first collision at address 5
    for (int k = 0; k < 5; k++) strobe(12'hFFC);
    vga       = 12'd5;
    sample_en = 1'b1;
    mic_in    = 12'hFFC;
    @(negedge clk);
    sample_en = 1'b0;
    check("rfirst_old", wave_sample, 5);
    @(negedge clk);
    check("rfirst_new", wave_sample, 1023);
    rd(12'd6, rv);
    check("rfirst_neighbour", rv, 6);

    // Reset mid-FILL at address 600, coincident with a strobe
    for (int k = 6; k < 600; k++) strobe(12'(k * 4));
    sample_en = 1'b1;
    mic_in    = 12'h000;
    rst_n     = 1'b0;
    trig_en   = 1'b1;
    freeze    = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    check("midrst_busy", wr_busy, 0);
    check("midrst_wave", wave_sample, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) strobe(12'h000);
    check("arm_freeze_busy", wr_busy, 0);
    rd(12'd600, rv);
    check("midrst_no_write_600", rv, 600);
    rd(12'd599, rv);
    check("midrst_keep_599", rv, 599);
    freeze  = 1'b0;
    trig_en = 1'b0;
    @(negedge clk);
    strobe(12'h888);
    rd(12'd0, rv);
    check("restart_addr0", rv, 10'h222);
    rd(12'd1, rv);
    check("restart_addr1_old", rv, 1023);
    check("fd_after_reset", fd_cnt, 1);

    // Triggered frame with freeze raised mid-FILL
    rst_n   = 1'b0;
    trig_en = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    check("waittrig_busy", wr_busy, 1);
    strobe(12'h100);
    strobe(12'h100);
    rd(12'd0, rv);
    check("no_trig_yet", rv, 10'h222);
    strobe(12'h900);
    for (int k = 1; k <= 600; k++) strobe(12'h400);
    freeze = 1'b1;
    for (int k = 601; k <= 1278; k++) strobe(12'h400);
    check("freeze_fill_busy", wr_busy, 1);
    check("freeze_fd_pending", fd_cnt, 1);
    strobe(12'h400);
    check("trig_fd_pulse", frame_done, 1);
    cyc(2);
    check("freeze_hold_busy", wr_busy, 0);
    for (int k = 0; k < 3; k++) strobe(12'hFFC);
    rd(12'd0, rv);
    check("trig_buf0", rv, 10'h240);
    rd(12'd1, rv);
    check("trig_buf1", rv, 10'h100);
    rd(12'd1279, rv);
    check("trig_buf1279", rv, 10'h100);
    check("fd_twice", fd_cnt, 2);
    check("frozen_busy", wr_busy, 0);
    freeze = 1'b0;
    @(negedge clk);
    check("unfreeze_arm", wr_busy, 0);
    @(negedge clk);
    check("unfreeze_waittrig", wr_busy, 1);

    // Auto-trigger after 2047 strobes without a crossing
    for (int k = 0; k < 2047; k++) strobe(12'h000);
    rd(12'd0, rv);
    check("auto_nowrite_2047", rv, 10'h240);
    check("auto_still_waiting", wr_busy, 1);
    strobe(12'h000);
    rd(12'd0, rv);
    check("auto_write_2048", rv, 0);
    strobe(12'h008);
    rd(12'd1, rv);
    check("auto_next_addr1", rv, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 SHALL have a single clock and a synchronous, active-low reset; there is no other clock domain.
REQ-002 CLK_VGA  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  synchronous active-low reset, sampled on CLK_VGA.
REQ-004 sample_en  in  1  one-cycle strobe per new microphone sample (20 kHz rate), already in the CLK_VGA domain.
REQ-005 mic_in  in  12  raw unsigned microphone sample; valid only in cycles where sample_en=1.
REQ-006 trig_en  in  1  1 = align each frame to a rising mid-scale crossing; 0 = free-run.
REQ-007 freeze  in  1  1 = stop starting new frames and keep the current buffer contents.
REQ-008 VGA_HORZ_COORD  in  12  display read address.
REQ-009 wave_sample  out  10  stored sample at the read address, registered.
REQ-010 wr_busy  out  1  high while in WAIT_TRIG or FILL.
REQ-011 frame_done  out  1  one-cycle pulse when entry 1279 has been written.

Function
REQ-012 SHALL hold a 1280 x 10-bit sample buffer with one write port (this block) and one read port (display).
REQ-013 Scaled sample = mic_in[11:2] (truncation, no rounding).
REQ-014 prev register: loads the scaled sample on every sample_en in every state; reset value 0.
REQ-015 Crossing: prev < 512 and current scaled sample >= 512, evaluated in the same sample_en cycle.
REQ-016 FSM states: ARM, WAIT_TRIG, FILL, HOLD; reset state ARM.
REQ-017 ARM transitions, decided in one cycle:
- freeze=1 -> stay in ARM.
- trig_en=1 -> WAIT_TRIG, timeout counter cleared.
- otherwise -> FILL, write address 0.
REQ-018 WAIT_TRIG, on each sample_en:
- crossing -> write current sample at address 0; go to FILL with address 1.
- no crossing -> increment the 11-bit timeout counter.
- counter reaches 2047 with no crossing -> auto-trigger: that same sample is written at address 0 and the FSM goes to FILL with address 1.
REQ-019 FILL, on each sample_en:
- write the scaled sample at the current address, then increment the address.
- writing address 1279 -> frame_done=1 in the following cycle; FSM goes to HOLD.
REQ-020 HOLD: freeze=1 -> stay in HOLD; freeze=0 -> ARM on the next cycle.
REQ-021 freeze asserted during WAIT_TRIG or FILL SHALL NOT abort the frame; it takes effect in HOLD or ARM.
REQ-022 Cycles without sample_en SHALL NOT write, advance the address or advance the timeout counter.
REQ-023 Read port:
- wave_sample = buffer[VGA_HORZ_COORD] one cycle after the address is presented.
- VGA_HORZ_COORD >= 1280 -> wave_sample = 0 one cycle later.
REQ-024 Read and write to the same address in the same cycle -> the read returns the old contents (read-first).
REQ-025 trig_en changes take effect only at the next ARM decision.

Reset
REQ-026 After rst_n=0:
- FSM in ARM, write address 0, timeout counter 0, prev 0.
- wave_sample=0, wr_busy=0, frame_done=0.
REQ-027 Reset mid-frame SHALL abandon the frame with no further writes; buffer contents are not cleared (undefined before the first frame_done).
REQ-028 Reset SHALL have priority over sample_en in the same cycle.

Verification
REQ-029 Free-run (trig_en=0, freeze=0): 1280 sample_en strobes with mic_in = index*4 -> buffer[k] = k mod 1024; frame_done pulses exactly once, one cycle after the 1280th strobe.
REQ-030 Trigger: trig_en=1, feed 0x100, 0x100, 0x900 -> buffer[0] = 0x240; 1279 further strobes -> frame_done.
REQ-031 Auto-trigger: trig_en=1, constant mic_in=0x000 -> the first write occurs on strobe 2048 after entering WAIT_TRIG.
REQ-032 Freeze: assert freeze mid-FILL -> the frame completes, FSM stays in HOLD, buffer stable, wr_busy=0; deassert -> ARM, then a new frame starts.
REQ-033 Read port: address 1500 -> wave_sample=0; same-cycle read and write at address 5 -> old value returned, new value on the next read.
REQ-034 Reset mid-FILL at address 600 -> wr_busy=0 next cycle, no writes until ARM exits, the next frame starts at address 0.
